// File: rtl/stage4_sram.sv
// Memory stage and MEM/WB register for a 16-bit external SRAM.
// Each 32-bit access is split into low and high half-word cycles.
module stage4_sram #(
    parameter int          ADDR_WIDTH  = 18,
    parameter int          WAIT_CYCLES = 5,
    parameter logic [31:0] BASE_ADDR   = 32'd1024
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [31:0]           ALUResult,
    input  logic [31:0]           StoreVal,
    input  logic                  MEM_R_EN,
    input  logic                  MEM_W_EN,
    input  logic                  MEM_WB_EN,
    input  logic [4:0]            Dest,
    output logic                  Freeze,
    output logic [31:0]           ALUOut,
    output logic [31:0]           DataMemoryOut,
    output logic                  MEM_R_ENOut,
    output logic                  MEM_WB_ENOut,
    output logic [4:0]            DestOut,
    output logic [ADDR_WIDTH-1:0] SRAM_ADDR,
    output logic [15:0]           SRAM_WDATA,
    input  logic [15:0]           SRAM_RDATA,
    output logic                  SRAM_WE_N,
    output logic                  SRAM_OE_N
);

    typedef enum logic [1:0] {
        IDLE,
        LOW,
        HIGH,
        DONE
    } state_t;

    localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

    state_t                state;
    logic [CW-1:0]         cnt;
    logic [15:0]           rd_lo;
    logic [15:0]           rd_hi;
    logic [31:0]           word;
    logic [ADDR_WIDTH-1:0] addr_lo;
    logic [ADDR_WIDTH-1:0] addr_hi;
    logic                  req;
    logic                  is_load;
    logic                  is_store;
    logic                  last;

    assign word     = (ALUResult - BASE_ADDR) >> 2;
    assign addr_lo  = ADDR_WIDTH'({word, 1'b0});
    assign addr_hi  = ADDR_WIDTH'({word, 1'b1});
    assign req      = MEM_R_EN | MEM_W_EN;
    // A request with both enables set is serviced as a load only.
    assign is_load  = MEM_R_EN;
    assign is_store = MEM_W_EN & ~MEM_R_EN;
    assign last     = (cnt == CW'(WAIT_CYCLES - 1));

    assign Freeze = ((state == IDLE) & req)
                  | (state == LOW)
                  | (state == HIGH);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            cnt        <= '0;
            rd_lo      <= '0;
            rd_hi      <= '0;
            SRAM_ADDR  <= '0;
            SRAM_WDATA <= '0;
            SRAM_WE_N  <= 1'b1;
            SRAM_OE_N  <= 1'b1;
        end else begin
            unique case (state)
                IDLE: begin
                    if (req) begin
                        state      <= LOW;
                        cnt        <= '0;
                        SRAM_ADDR  <= addr_lo;
                        SRAM_WDATA <= StoreVal[15:0];
                        SRAM_OE_N  <= ~is_load;
                        SRAM_WE_N  <= ~is_store;
                    end
                end
                LOW: begin
                    if (last) begin
                        if (is_load) rd_lo <= SRAM_RDATA;
                        state      <= HIGH;
                        cnt        <= '0;
                        SRAM_ADDR  <= addr_hi;
                        SRAM_WDATA <= StoreVal[31:16];
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                HIGH: begin
                    if (last) begin
                        if (is_load) rd_hi <= SRAM_RDATA;
                        state     <= DONE;
                        cnt       <= '0;
                        SRAM_WE_N <= 1'b1;
                        SRAM_OE_N <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ALUOut        <= '0;
            DataMemoryOut <= '0;
            MEM_R_ENOut   <= 1'b0;
            MEM_WB_ENOut  <= 1'b0;
            DestOut       <= '0;
        end else if (!Freeze) begin
            ALUOut        <= ALUResult;
            DataMemoryOut <= MEM_R_EN ? {rd_hi, rd_lo} : 32'h0;
            MEM_R_ENOut   <= MEM_R_EN;
            MEM_WB_ENOut  <= MEM_WB_EN;
            DestOut       <= Dest;
        end
    end

endmodule

// File: tb/tb_stage4_sram.sv
// Randomized bench for stage4_sram against a word-level memory model.
// A behavioural 16-bit SRAM sits on the DUT's SRAM port.
module tb_stage4_sram;

    localparam int AW = 18;
    localparam int W  = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic [31:0]   ALUResult;
    logic [31:0]   StoreVal;
    logic          MEM_R_EN;
    logic          MEM_W_EN;
    logic          MEM_WB_EN;
    logic [4:0]    Dest;
    logic          Freeze;
    logic [31:0]   ALUOut;
    logic [31:0]   DataMemoryOut;
    logic          MEM_R_ENOut;
    logic          MEM_WB_ENOut;
    logic [4:0]    DestOut;
    logic [AW-1:0] SRAM_ADDR;
    logic [15:0]   SRAM_WDATA;
    logic [15:0]   SRAM_RDATA;
    logic          SRAM_WE_N;
    logic          SRAM_OE_N;

    int checks = 0;
    int errors = 0;

    logic [15:0] sram [0:(1<<AW)-1];
    logic [31:0] ref_mem [int unsigned];

    always #5 clk = ~clk;

    stage4_sram #(
        .ADDR_WIDTH (AW),
        .WAIT_CYCLES(W),
        .BASE_ADDR  (32'd1024)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .ALUResult    (ALUResult),
        .StoreVal     (StoreVal),
        .MEM_R_EN     (MEM_R_EN),
        .MEM_W_EN     (MEM_W_EN),
        .MEM_WB_EN    (MEM_WB_EN),
        .Dest         (Dest),
        .Freeze       (Freeze),
        .ALUOut       (ALUOut),
        .DataMemoryOut(DataMemoryOut),
        .MEM_R_ENOut  (MEM_R_ENOut),
        .MEM_WB_ENOut (MEM_WB_ENOut),
        .DestOut      (DestOut),
        .SRAM_ADDR    (SRAM_ADDR),
        .SRAM_WDATA   (SRAM_WDATA),
        .SRAM_RDATA   (SRAM_RDATA),
        .SRAM_WE_N    (SRAM_WE_N),
        .SRAM_OE_N    (SRAM_OE_N)
    );

    // Undriven bus returns a marker so reads without OE_N are visible.
    assign SRAM_RDATA = SRAM_OE_N ? 16'hA5A5 : sram[SRAM_ADDR];

    always @(posedge clk) begin
        if (!SRAM_WE_N) sram[SRAM_ADDR] <= SRAM_WDATA;
    end

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    function automatic int unsigned key_of(input logic [31:0] a);
        logic [31:0] off;
        off = a - 32'd1024;
        return (off / 4) % (1 << (AW - 1));
    endfunction

    task automatic run_op(input logic [31:0] a,
                          input logic [31:0] sv,
                          input logic r,
                          input logic w,
                          input logic wb,
                          input logic [4:0] d);
        int fz;
        int we;
        int oe;
        int n;
        logic f;
        logic [31:0] exp_data;
        int unsigned k;
        ALUResult = a;
        StoreVal  = sv;
        MEM_R_EN  = r;
        MEM_W_EN  = w;
        MEM_WB_EN = wb;
        Dest      = d;
        fz = 0;
        we = 0;
        oe = 0;
        n  = 0;
        do begin
            @(negedge clk);
            f = Freeze;
            if (Freeze) fz++;
            if (!SRAM_WE_N) we++;
            if (!SRAM_OE_N) oe++;
            @(posedge clk);
            #1;
            n++;
        end while (f && n < 100);
        if (f) check("freeze_stuck", {31'b0, f}, 32'h0);
        k = key_of(a);
        exp_data = 32'h0;
        if (r) exp_data = ref_mem.exists(k) ? ref_mem[k] : 32'h0;
        if (w && !r) ref_mem[k] = sv;
        check("stall",    fz, (r | w) ? 1 + 2 * W : 0);
        check("we_low",   we, (w && !r) ? 2 * W : 0);
        check("oe_low",   oe, r ? 2 * W : 0);
        check("alu_out",  ALUOut, a);
        check("data_out", DataMemoryOut, exp_data);
        check("r_en_out", {31'b0, MEM_R_ENOut}, {31'b0, r});
        check("wb_en_out", {31'b0, MEM_WB_ENOut}, {31'b0, wb});
        check("dest_out", {27'b0, DestOut}, {27'b0, d});
    endtask

    initial begin
        for (int i = 0; i < (1 << AW); i++) sram[i] = 16'h0;
        rst       = 1'b0;
        ALUResult = '0;
        StoreVal  = '0;
        MEM_R_EN  = 1'b0;
        MEM_W_EN  = 1'b0;
        MEM_WB_EN = 1'b0;
        Dest      = '0;
        #12;
        check("rst_freeze", {31'b0, Freeze}, 32'h0);
        check("rst_we_n",   {31'b0, SRAM_WE_N}, 32'h1);
        check("rst_oe_n",   {31'b0, SRAM_OE_N}, 32'h1);
        check("rst_addr",   {14'b0, SRAM_ADDR}, 32'h0);
        check("rst_wdata",  {16'b0, SRAM_WDATA}, 32'h0);
        check("rst_alu",    ALUOut, 32'h0);
        check("rst_data",   DataMemoryOut, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;

        run_op(32'h1234, 32'h0, 1'b0, 1'b0, 1'b1, 5'd7);

        // Store to a word the random traffic never touches, then abort it.
        ALUResult = 32'd1024 + 32'd400;
        StoreVal  = 32'h1357_9BDF;
        MEM_W_EN  = 1'b1;
        MEM_WB_EN = 1'b0;
        Dest      = 5'd0;
        repeat (3) @(posedge clk);
        #2;
        rst       = 1'b0;
        ALUResult = '0;
        StoreVal  = '0;
        MEM_W_EN  = 1'b0;
        #1;
        check("abort_we_n",   {31'b0, SRAM_WE_N}, 32'h1);
        check("abort_freeze", {31'b0, Freeze}, 32'h0);
        check("abort_alu",    ALUOut, 32'h0);
        check("abort_dest",   {27'b0, DestOut}, 32'h0);
        check("abort_addr",   {14'b0, SRAM_ADDR}, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("post_abort_we_n",   {31'b0, SRAM_WE_N}, 32'h1);
        check("post_abort_freeze", {31'b0, Freeze}, 32'h0);

        run_op(32'd1024, 32'hDEAD_BEEF, 1'b0, 1'b1, 1'b0, 5'd0);
        check("sram_lo", {16'b0, sram[0]}, 32'h0000_BEEF);
        check("sram_hi", {16'b0, sram[1]}, 32'h0000_DEAD);
        run_op(32'd1024, 32'h0, 1'b1, 1'b0, 1'b1, 5'd3);
        run_op(32'd1028, 32'h0, 1'b1, 1'b0, 1'b1, 5'd4);
        run_op(32'hCAFE_0001, 32'h0, 1'b0, 1'b0, 1'b1, 5'd9);
        run_op(32'd1032, 32'h0BAD_F00D, 1'b0, 1'b1, 1'b0, 5'd0);
        run_op(32'd1032, 32'h1111_2222, 1'b1, 1'b1, 1'b1, 5'd12);
        run_op(32'd1032, 32'h0, 1'b1, 1'b0, 1'b1, 5'd13);

        for (int t = 0; t < 60; t++) begin
            logic [31:0] a;
            logic [1:0]  kind;
            int unsigned mode;
            kind = 2'($urandom_range(0, 3));
            mode = $urandom_range(0, 2);
            a = 32'd1024 + 32'($urandom_range(0, 31)) * 4;
            if (mode == 1) a = a + (32'd1 << (AW + 1));
            if (mode == 2) a = 32'd1024 - 32'($urandom_range(1, 4)) * 4;
            a = a + 32'($urandom_range(0, 3));
            unique case (kind)
                2'd0: run_op($urandom, 32'h0, 1'b0, 1'b0,
                             1'($urandom), 5'($urandom));
                2'd1: run_op(a, $urandom, 1'b0, 1'b1, 1'b0, 5'($urandom));
                2'd2: run_op(a, 32'h0, 1'b1, 1'b0, 1'b1, 5'($urandom));
                2'd3: run_op(a, $urandom, 1'b1, 1'b1, 1'b1, 5'($urandom));
            endcase
        end

        run_op(32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 5'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
